alarm_key_fsm: RTL and testbench

- Control FSM directly upstream of the key register. Turns raw keypad codes plus the ALARM/TIME buttons into the one-cycle `shift` strobe that the key register uses to shift digits in.
- Also produces the load strobes (`load_new_a`, `load_new_c`) that commit the buffered digits to the alarm or current-time registers, and the display-select outputs for the display mux.
- Enforces one shift per key press and an inactivity timeout on digit entry.

---
 rtl/alarm_key_fsm.sv | 135 +++++++++++++
 tb/tb_alarm_key_fsm.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alarm_key_fsm.sv
// Keypad entry control for the alarm clock: shift, load and display-select strobes.
// Optional entry inactivity timeout is built when ALARM_KEY_FSM_TIMEOUT_EN is defined.
module alarm_key_fsm #(
  parameter int unsigned TIMEOUT_SEC = 10,
  parameter logic [3:0]  NOKEY       = 4'd10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       alarm_button,
  input  logic       time_button,
  output logic       shift,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       show_new_time,
  output logic       show_a,
  output logic       entry_timeout
);

  typedef enum logic [2:0] {
    StShowTime       = 3'd0,
    StKeyStored      = 3'd1,
    StKeyWaited      = 3'd2,
    StKeyEntry       = 3'd3,
    StSetAlarmTime   = 3'd4,
    StSetCurrentTime = 3'd5,
    StShowAlarm      = 3'd6
  } state_e;

  state_e state_q, state_d;
  logic   is_digit;
  logic   expire;
  logic   timeout_fire;

  assign is_digit = (key != NOKEY) && (key <= 4'd9);

`ifdef ALARM_KEY_FSM_TIMEOUT_EN
  localparam logic [3:0] TimeoutLast = 4'(TIMEOUT_SEC - 1);
  localparam logic [3:0] TimeoutMax  = 4'(TIMEOUT_SEC);

  logic [3:0] tcnt_q, tcnt_d;
  logic       in_entry_q, in_entry_d;

  assign expire     = one_second && (tcnt_q == TimeoutLast);
  assign in_entry_q = (state_q == StKeyWaited) || (state_q == StKeyEntry);
  assign in_entry_d = (state_d == StKeyWaited) || (state_d == StKeyEntry);

  // Count only while staying inside the waited/entry pair; any other path clears it.
  always_comb begin
    tcnt_d = '0;
    if (in_entry_q && in_entry_d) begin
      tcnt_d = (one_second && (tcnt_q != TimeoutMax)) ? tcnt_q + 4'd1 : tcnt_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end
`else
  logic unused_one_second;
  assign unused_one_second = one_second;
  assign expire            = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    timeout_fire = 1'b0;
    case (state_q)
      StShowTime: begin
        if (alarm_button) begin
          state_d = StShowAlarm;
        end else if (is_digit) begin
          state_d = StKeyStored;
        end
      end
      StKeyStored: state_d = StKeyWaited;
      StKeyWaited: begin
        if (expire) begin
          state_d      = StShowTime;
          timeout_fire = 1'b1;
        end else if (!is_digit) begin
          state_d = StKeyEntry;
        end
      end
      StKeyEntry: begin
        if (alarm_button) begin
          state_d = StSetAlarmTime;
        end else if (time_button) begin
          state_d = StSetCurrentTime;
        end else if (is_digit) begin
          state_d = StKeyStored;
        end else if (expire) begin
          state_d      = StShowTime;
          timeout_fire = 1'b1;
        end
      end
      StSetAlarmTime:   state_d = StShowTime;
      StSetCurrentTime: state_d = StShowTime;
      StShowAlarm: begin
        if (!alarm_button) begin
          state_d = StShowTime;
        end
      end
      default: state_d = StShowTime;
    endcase
  end

  // Outputs are registered from the next state, so they always match the state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StShowTime;
      shift         <= 1'b0;
      load_new_a    <= 1'b0;
      load_new_c    <= 1'b0;
      show_new_time <= 1'b0;
      show_a        <= 1'b0;
      entry_timeout <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift         <= (state_d == StKeyStored);
      load_new_a    <= (state_d == StSetAlarmTime);
      load_new_c    <= (state_d == StSetCurrentTime);
      show_new_time <= (state_d == StKeyStored) || (state_d == StKeyWaited) ||
                       (state_d == StKeyEntry);
      show_a        <= (state_d == StShowAlarm);
      entry_timeout <= timeout_fire;
    end
  end

endmodule

// File: tb/tb_alarm_key_fsm.sv
// Directed self-checking bench for alarm_key_fsm.
// Output vectors are packed {shift, load_new_a, load_new_c, show_new_time, show_a, entry_timeout}.
module tb_alarm_key_fsm;

  localparam logic [3:0] NoKey = 4'd10;

  logic       clock = 1'b0;
  logic       reset;
  logic       one_second;
  logic [3:0] key;
  logic       alarm_button;
  logic       time_button;
  logic       shift, load_new_a, load_new_c, show_new_time, show_a, entry_timeout;

  int checks = 0;
  int errors = 0;

  alarm_key_fsm #(
    .TIMEOUT_SEC(10),
    .NOKEY      (NoKey)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .one_second   (one_second),
    .key          (key),
    .alarm_button (alarm_button),
    .time_button  (time_button),
    .shift        (shift),
    .load_new_a   (load_new_a),
    .load_new_c   (load_new_c),
    .show_new_time(show_new_time),
    .show_a       (show_a),
    .entry_timeout(entry_timeout)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [5:0] exp);
    check(tag, {shift, load_new_a, load_new_c, show_new_time, show_a, entry_timeout}, exp);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic enter_digit(input logic [3:0] d);
    key = d;
    step();
    check_outs("digit_shift", 6'b100100);
    step();
    check_outs("digit_wait", 6'b000100);
    key = NoKey;
    step();
    check_outs("digit_entry", 6'b000100);
  endtask

  initial begin
    reset        = 1'b1;
    one_second   = 1'b0;
    key          = NoKey;
    alarm_button = 1'b0;
    time_button  = 1'b0;

    // Reset and idle
    step();
    check_outs("reset_c1", 6'b000000);
    step();
    check_outs("reset_c2", 6'b000000);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_outs("idle", 6'b000000);
    end

    // Held digits shift exactly once
    key = 4'd3;
    step();
    check_outs("k3_shift", 6'b100100);
    for (int i = 0; i < 4; i++) begin
      step();
      check_outs("k3_held", 6'b000100);
    end
    key = NoKey;
    step();
    check_outs("k3_release", 6'b000100);
    key = 4'd6;
    step();
    check_outs("k6_shift", 6'b100100);
    for (int i = 0; i < 2; i++) begin
      step();
      check_outs("k6_held", 6'b000100);
    end
    key = NoKey;
    step();
    check_outs("k6_release", 6'b000100);

    // Commit to current time
    enter_digit(4'd1);
    enter_digit(4'd2);
    enter_digit(4'd3);
    enter_digit(4'd0);
    time_button = 1'b1;
    step();
    check_outs("load_c", 6'b001000);
    time_button = 1'b0;
    step();
    check_outs("after_load_c", 6'b000000);

    // Commit to alarm
    enter_digit(4'd5);
    enter_digit(4'd9);
    alarm_button = 1'b1;
    step();
    check_outs("load_a", 6'b010000);
    alarm_button = 1'b0;
    step();
    check_outs("after_load_a", 6'b000000);

    // Both buttons together: alarm wins
    enter_digit(4'd7);
    alarm_button = 1'b1;
    time_button  = 1'b1;
    step();
    check_outs("both_btn", 6'b010000);
    alarm_button = 1'b0;
    time_button  = 1'b0;
    step();
    check_outs("after_both", 6'b000000);

    // Inactivity timeout
    enter_digit(4'd4);
    for (int i = 1; i <= 9; i++) begin
      one_second = 1'b1;
      step();
      check_outs("tick", 6'b000100);
      one_second = 1'b0;
      step();
      check_outs("tick_gap", 6'b000100);
    end
    one_second = 1'b1;
    step();
    one_second = 1'b0;
`ifdef ALARM_KEY_FSM_TIMEOUT_EN
    check_outs("timeout_pulse", 6'b000001);
    step();
    check_outs("timeout_after", 6'b000000);
`else
    check_outs("no_timeout", 6'b000100);
    step();
    check_outs("no_timeout_hold", 6'b000100);
    time_button = 1'b1;
    step();
    check_outs("no_timeout_exit", 6'b001000);
    time_button = 1'b0;
    step();
    check_outs("no_timeout_idle", 6'b000000);
`endif

    // Show alarm ignores digits
    alarm_button = 1'b1;
    key          = 4'd5;
    for (int i = 0; i < 6; i++) begin
      step();
      check_outs("show_a", 6'b000010);
    end
    alarm_button = 1'b0;
    key          = NoKey;
    step();
    check_outs("show_a_release", 6'b000000);

    // Asynchronous reset mid-entry
    key = 4'd8;
    step();
    check_outs("k8_shift", 6'b100100);
    step();
    check_outs("k8_wait", 6'b000100);
    #2;
    reset = 1'b1;
    #1;
    check_outs("async_reset", 6'b000000);
    step();
    check_outs("reset_held", 6'b000000);
    key   = NoKey;
    reset = 1'b0;
    step();
    check_outs("post_reset", 6'b000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
